// File: rtl/pixel_pkg.sv
// Pixel type shared by the deframer, frame controller and filter pipeline.
package pixel_pkg;
    typedef logic [23:0] pixel_t;
endpackage

// File: rtl/axis_if.sv
// Valid/ready pixel channel; ok marks the cycle in which a transfer happens.
interface axis_if;
    logic              vld;
    logic              rdy;
    pixel_pkg::pixel_t data;
    logic              ok;

    assign ok = vld & rdy;

    modport master (output vld, output data, input rdy, input ok);
    modport slave  (input vld, input data, output rdy, input ok);
endinterface

// File: rtl/frame_ctrl.sv
// Frame controller: arms capture on start, passes pixels through a 2-entry skid
// buffer and checks line/frame dimensions. Optional watchdog: FRAME_TIMEOUT_EN.
module frame_ctrl #(
    parameter int W_CNT       = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [W_CNT-1:0] cfg_width,
    input  logic [W_CNT-1:0] cfg_height,
    input  logic             line,
    input  logic             done,
    axis_if.slave            axis_i,
    axis_if.master           axis_o,
    output logic             busy,
    output logic             frame_done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [W_CNT-1:0] line_cnt,
    output logic [W_CNT-1:0] pix_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN, S_ERR} state_t;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_WIDTH   = 3'd1;
    localparam logic [2:0] E_HEIGHT  = 3'd2;
    localparam logic [2:0] E_TIMEOUT = 3'd3;
    localparam logic [2:0] E_OVF     = 3'd4;

    state_t            state_q, state_d;
    pixel_pkg::pixel_t buf_q [2];
    pixel_pkg::pixel_t buf_d [2];
    logic [1:0]        cnt_q, cnt_d;
    logic              line_q, done_q;
    logic [W_CNT-1:0]  cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d;
    logic [W_CNT-1:0]  line_cnt_q, line_cnt_d, pix_cnt_q, pix_cnt_d;
    logic              err_q, err_d;
    logic [2:0]        code_q, code_d;

    logic              rdy_int, acc, pop, flush;
    logic              line_rise, done_rise;
    logic              ovf, werr, herr, terr;
    logic [2:0]        det_code;
    logic [W_CNT-1:0]  pix_sum, line_sum;

    assign line_rise = line & ~line_q;
    assign done_rise = done & ~done_q;

    always_comb begin
        rdy_int = 1'b0;
        case (state_q)
            S_IDLE, S_ERR: rdy_int = 1'b1;
            S_RUN:         rdy_int = (cnt_q != 2'd2);
            default:       rdy_int = 1'b0;
        endcase
    end

    assign axis_i.rdy  = rst & rdy_int;
    assign axis_o.vld  = (cnt_q != 2'd0);
    assign axis_o.data = buf_q[0];

    assign acc = (state_q == S_RUN) & axis_i.ok;
    assign pop = axis_o.ok;

    // Running totals include same-cycle acceptances/edges so the checks see the final count.
    assign pix_sum  = (acc && pix_cnt_q != '1) ? pix_cnt_q + W_CNT'(1) : pix_cnt_q;
    assign line_sum = (line_rise && line_cnt_q != '1) ? line_cnt_q + W_CNT'(1) : line_cnt_q;

    assign ovf  = (state_q == S_RUN) & axis_i.vld & ~axis_i.rdy;
    assign werr = (state_q == S_RUN) & line_rise & (pix_sum != cfg_w_q);
    assign herr = (state_q == S_RUN) & done_rise & (line_sum != cfg_h_q);

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = '0;
        if (state_q == S_RUN && !acc) wd_d = wd_q + TW'(1);
    end

    assign terr = (state_q == S_RUN) & ~acc & (wd_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst) wd_q <= '0;
        else      wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign terr = 1'b0;
`endif

    always_comb begin
        det_code = E_NONE;
        if (ovf)       det_code = E_OVF;
        else if (werr) det_code = E_WIDTH;
        else if (herr) det_code = E_HEIGHT;
        else if (terr) det_code = E_TIMEOUT;
    end

    always_comb begin
        state_d    = state_q;
        cfg_w_d    = cfg_w_q;
        cfg_h_d    = cfg_h_q;
        line_cnt_d = line_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        err_d      = err_q;
        code_d     = code_q;
        flush      = 1'b0;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d    = S_RUN;
                    cfg_w_d    = cfg_width;
                    cfg_h_d    = cfg_height;
                    line_cnt_d = '0;
                    pix_cnt_d  = '0;
                    err_d      = 1'b0;
                    code_d     = E_NONE;
                end
            end
            S_RUN: begin
                pix_cnt_d  = line_rise ? '0 : pix_sum;
                line_cnt_d = line_sum;
                if (det_code != E_NONE) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = det_code;
                    flush   = 1'b1;
                end else if (done_rise) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
            code_d  = E_NONE;
            flush   = 1'b1;
        end
    end

    // Head lives in entry 0; a push lands behind whatever survives this cycle's pop.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            if (pop) buf_d[0] = buf_q[1];
            if (acc) begin
                if (pop) buf_d[cnt_q[1]] = axis_i.data;
                else     buf_d[cnt_q[0]] = axis_i.data;
            end
            cnt_d = cnt_q + {1'b0, acc} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            buf_q      <= '{default: '0};
            cnt_q      <= 2'd0;
            line_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_w_q    <= '0;
            cfg_h_q    <= '0;
            line_cnt_q <= '0;
            pix_cnt_q  <= '0;
            err_q      <= 1'b0;
            code_q     <= E_NONE;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            line_q     <= line;
            done_q     <= done;
            cfg_w_q    <= cfg_w_d;
            cfg_h_q    <= cfg_h_d;
            line_cnt_q <= line_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign busy       = (state_q == S_RUN) | (state_q == S_DRAIN) | (state_q == S_FIN);
    assign frame_done = (state_q == S_FIN);
    assign err        = err_q;
    assign err_code   = code_q;
    assign line_cnt   = line_cnt_q;
    assign pix_cnt    = pix_cnt_q;
endmodule

// File: tb/tb_frame_ctrl.sv
// Scoreboard bench for frame_ctrl: accepted pixels are queued as expectations and
// a negedge monitor compares every output handshake; directed phases check status.
module tb_frame_ctrl;
    import pixel_pkg::*;
    localparam int W = 16;
`ifdef FRAME_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1000000;
`endif

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, line = 1'b0, done = 1'b0;
    logic [W-1:0] cfg_w = '0, cfg_h = '0;
    logic busy, frame_done, err;
    logic [2:0] err_code;
    logic [W-1:0] line_cnt, pix_cnt;

    axis_if in_if();
    axis_if out_if();

    frame_ctrl #(.W_CNT(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_width(cfg_w), .cfg_height(cfg_h), .line(line), .done(done),
        .axis_i(in_if.slave), .axis_o(out_if.master),
        .busy(busy), .frame_done(frame_done), .err(err), .err_code(err_code),
        .line_cnt(line_cnt), .pix_cnt(pix_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { pixel_t d; int c; } item_t;
    item_t exp_q[$];
    item_t it;
    int checks = 0, errors = 0, cyc = 0, fd_cnt = 0;
    bit cap_en = 0, lat_chk = 0, rnd_rdy = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture accepted input pixels, check every output handshake.
    always @(negedge clk) begin
        if (in_if.vld && in_if.rdy && cap_en) exp_q.push_back('{d: in_if.data, c: cyc});
        if (out_if.vld && out_if.rdy) begin
            chk("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                chk("pix_data", out_if.data, it.d);
                if (lat_chk) chk("pix_latency", cyc - it.c, 1);
            end
        end
        if (frame_done) fd_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) out_if.rdy = 1'($urandom_range(0, 1));
    end

    task automatic push_pix(input pixel_t d, input bit ln, input bit dn = 1'b0);
        int n = 0;
        while (!in_if.rdy && n < 64) begin step(); n++; end
        if (n >= 64) begin
            checks++; errors++;
            $display("FAIL in_rdy_wait: got rdy=0 for %0d cycles, expected rdy=1", n);
        end
        in_if.vld = 1'b1; in_if.data = d; line = ln; done = dn;
        step();
        in_if.vld = 1'b0; line = 1'b0; done = 1'b0;
    endtask

    task automatic wait_fd(input string nm);
        int f0 = fd_cnt;
        int n = 0;
        while (fd_cnt == f0 && n < 200) begin step(); n++; end
        step();
        chk(nm, fd_cnt - f0, 1);
    endtask

    task automatic do_start(input int w, input int h);
        cfg_w = W'(w); cfg_h = W'(h);
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_rdy"}, in_if.rdy, 0);
        chk({tag, "_out_vld"}, out_if.vld, 0);
        chk({tag, "_out_data"}, out_if.data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_line_cnt"}, line_cnt, 0);
        chk({tag, "_pix_cnt"}, pix_cnt, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL sim_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int f0;
        pixel_t p;
        in_if.vld = 1'b0; in_if.data = '0; out_if.rdy = 1'b0;
        repeat (3) step();
        check_reset("rst");
        rst = 1'b1; step();
        chk("idle_in_rdy", in_if.rdy, 1);

        // Clean 4x2 frame at full rate, fixed data
        out_if.rdy = 1'b1; lat_chk = 1;
        do_start(4, 2);
        cap_en = 1;
        chk("run_busy", busy, 1);
        for (int i = 1; i <= 8; i++) begin
            p = pixel_t'(i) * 24'h010101;
            push_pix(p, (i % 4) == 0);
        end
        chk("clean_line_cnt", line_cnt, 2);
        chk("clean_pix_cnt", pix_cnt, 0);
        cap_en = 0; f0 = fd_cnt;
        done = 1'b1; step(); done = 1'b0;
        chk("clean_fd_e1", frame_done, 0);
        step(); chk("clean_fd_e2", frame_done, 1);
        step(); chk("clean_fd_e3", frame_done, 0);
        chk("clean_fd_count", fd_cnt - f0, 1);
        chk("clean_busy", busy, 0);
        chk("clean_err", err, 0);
        chk("clean_sb_empty", exp_q.size(), 0);
        chk("clean_line_hold", line_cnt, 2);
        lat_chk = 0;

        // Width error: line after 3 pixels
        do_start(4, 2);
        cap_en = 1;
        repeat (3) push_pix(pixel_t'($urandom), 1'b0);
        cap_en = 0;
        line = 1'b1; step(); line = 1'b0;
        chk("werr_err", err, 1);
        chk("werr_code", err_code, 1);
        chk("werr_out_vld", out_if.vld, 0);
        chk("werr_in_rdy", in_if.rdy, 1);
        chk("werr_sb_empty", exp_q.size(), 0);
        in_if.vld = 1'b1; in_if.data = pixel_t'($urandom); step(); in_if.vld = 1'b0;
        chk("err_discard_vld", out_if.vld, 0);
        chk("err_sticky_code", err_code, 1);
        do_start(4, 2);
        chk("restart_err", err, 0);
        chk("restart_code", err_code, 0);
        chk("restart_busy", busy, 1);
        chk("restart_line_cnt", line_cnt, 0);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort1_busy", busy, 0);

        // Backpressure: out stalled 5 cycles mid-line, then random ready
        do_start(4, 2);
        cap_en = 1;
        push_pix(pixel_t'($urandom), 1'b0);
        push_pix(pixel_t'($urandom), 1'b0);
        out_if.rdy = 1'b0;
        push_pix(pixel_t'($urandom), 1'b0);
        chk("bp_in_rdy_low", in_if.rdy, 0);
        chk("bp_out_vld", out_if.vld, 1);
        repeat (4) step();
        chk("bp_in_rdy_held", in_if.rdy, 0);
        out_if.rdy = 1'b1;
        push_pix(pixel_t'($urandom), 1'b1);
        rnd_rdy = 1;
        for (int i = 0; i < 4; i++) push_pix(pixel_t'($urandom), i == 3);
        cap_en = 0;
        done = 1'b1; step(); done = 1'b0;
        wait_fd("bp_frame_done");
        chk("bp_err", err, 0);
        chk("bp_sb_empty", exp_q.size(), 0);
        rnd_rdy = 0; step(); out_if.rdy = 1'b0;

        // Overflow: deframer pulses vld while rdy is low
        do_start(4, 2);
        cap_en = 1;
        push_pix(pixel_t'($urandom), 1'b0);
        push_pix(pixel_t'($urandom), 1'b0);
        cap_en = 0;
        chk("ovf_in_rdy", in_if.rdy, 0);
        in_if.vld = 1'b1; in_if.data = pixel_t'($urandom); step(); in_if.vld = 1'b0;
        exp_q.delete();
        chk("ovf_err", err, 1);
        chk("ovf_code", err_code, 4);
        chk("ovf_out_vld", out_if.vld, 0);
        abort = 1'b1; step(); abort = 1'b0;
        chk("ovf_abort_err", err, 0);
        chk("ovf_abort_code", err_code, 0);

        // Abort with 2 pixels buffered
        do_start(4, 2);
        cap_en = 1;
        push_pix(pixel_t'($urandom), 1'b0);
        push_pix(pixel_t'($urandom), 1'b0);
        cap_en = 0; f0 = fd_cnt;
        abort = 1'b1; step(); abort = 1'b0;
        exp_q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_out_vld", out_if.vld, 0);
        chk("abort_err", err, 0);
        chk("abort_fd", frame_done, 0);
        out_if.rdy = 1'b1;
        in_if.vld = 1'b1; in_if.data = pixel_t'($urandom); step(); in_if.vld = 1'b0;
        step();
        chk("idle_discard_vld", out_if.vld, 0);
        chk("abort_no_fd", fd_cnt - f0, 0);

        // Coincident last line and done edges
        for (int k = 0; k < 2; k++) begin
            do_start(2, 3 + k);
            cap_en = 1;
            for (int i = 0; i < 5; i++) push_pix(pixel_t'($urandom), (i % 2) == 1);
            if (k == 1) cap_en = 0;
            push_pix(pixel_t'($urandom), 1'b1, 1'b1);
            cap_en = 0;
            if (k == 0) begin
                wait_fd("coinc_frame_done");
                chk("coinc_err", err, 0);
                chk("coinc_line_cnt", line_cnt, 3);
                chk("coinc_sb_empty", exp_q.size(), 0);
            end else begin
                chk("coinc_h_err", err, 1);
                chk("coinc_h_code", err_code, 2);
                chk("coinc_h_sb_empty", exp_q.size(), 0);
                abort = 1'b1; step(); abort = 1'b0;
            end
        end

        // Random frames with random gaps and output ready
        rnd_rdy = 1;
        for (int f = 0; f < 4; f++) begin
            int ww, hh;
            ww = $urandom_range(2, 5);
            hh = $urandom_range(1, 3);
            do_start(ww, hh);
            cap_en = 1;
            for (int l = 0; l < hh; l++) begin
                for (int q = 0; q < ww; q++) begin
                    repeat ($urandom_range(0, 2)) step();
                    push_pix(pixel_t'($urandom), q == ww - 1);
                end
            end
            cap_en = 0;
            done = 1'b1; step(); done = 1'b0;
            wait_fd("rnd_frame_done");
            chk("rnd_err", err, 0);
            chk("rnd_line_cnt", line_cnt, 32'(hh));
            chk("rnd_sb_empty", exp_q.size(), 0);
        end
        rnd_rdy = 0; step(); out_if.rdy = 1'b1;

        // Watchdog
        do_start(4, 2);
`ifdef FRAME_TIMEOUT_EN
        repeat (TO - 1) step();
        chk("to_before", err, 0);
        step();
        chk("to_err", err, 1);
        chk("to_code", err_code, 3);
`else
        repeat (100) step();
        chk("no_to_err", err, 0);
        chk("no_to_busy", busy, 1);
`endif
        abort = 1'b1; step(); abort = 1'b0;

        // Reset mid-frame
        out_if.rdy = 1'b0;
        do_start(4, 2);
        cap_en = 1;
        push_pix(pixel_t'($urandom), 1'b0);
        push_pix(pixel_t'($urandom), 1'b0);
        cap_en = 0;
        rst = 1'b0; step();
        exp_q.delete();
        check_reset("midrst");
        rst = 1'b1; step();
        chk("post_rst_in_rdy", in_if.rdy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_ctrl.md
# frame_ctrl

Frame-level controller between the byte-stream sync/deframer and the filter pipeline. It arms capture on a host `start` and passes the deframed pixel stream through a 2-entry skid buffer. It also checks each line and frame against host-programmed dimensions and reports completion or the first error. The deframer's `axis_i.rdy` is driven from this block, not from the filter.

## Interface
- `W_CNT`, 16: width of dimension inputs and counters.
- `TIMEOUT_CYC`, 1000000: idle-cycle limit for the watchdog. Used only with `FRAME_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low; `rst==0` resets on the next edge.
- `start` in 1: host capture request. Sampled in IDLE and ERR only; latches `cfg_width`/`cfg_height`.
- `abort` in 1: host cancel. Honoured in every state.
- `cfg_width` in `W_CNT`: expected pixels per line.
- `cfg_height` in `W_CNT`: expected lines per frame.
- `line` in 1: deframer end-of-line strobe. Rising edge is detected internally.
- `done` in 1: deframer end-of-frame level. Rising edge is detected internally.
- `axis_i` axis_if.slave, `pixel_pkg::pixel_t`: pixels from the deframer.
- `axis_o` axis_if.master, `pixel_pkg::pixel_t`: pixels to the filter.
- `busy` out 1: high in RUN, DRAIN, FIN.
- `frame_done` out 1: one-cycle pulse after a clean frame.
- `err` out 1: sticky error flag.
- `err_code` out 3: 0 none, 1 width mismatch, 2 height mismatch, 3 timeout, 4 overflow.
- `line_cnt` out `W_CNT`: lines completed in the current frame.
- `pix_cnt` out `W_CNT`: pixels accepted in the current line.

## Operation
- States and transitions:
  - IDLE: `axis_i.rdy=1`; accepted pixels are discarded; `axis_o.vld=0`. `start` -> RUN.
  - RUN: accepted pixels enter the skid buffer. `done` edge -> DRAIN. Any error -> ERR.
  - DRAIN: `axis_i.rdy=0`; wait until the buffer is empty -> FIN.
  - FIN: one cycle; `frame_done=1` -> IDLE.
  - ERR: `axis_i.rdy=1`; accepted pixels are discarded; the buffer is flushed. `start` clears `err`/`err_code` and enters RUN with the new configuration.
  - `abort` from any state -> IDLE next cycle: buffer flushed, `err` cleared, no `frame_done`.
- Counter and check rules in RUN:
  - Acceptance is `axis_i.ok` (`vld && rdy`).
  - `pix_cnt` increments by 1 per acceptance and saturates at all-ones.
  - On a `line` edge, `pix_cnt` plus any same-cycle acceptance is compared to `cfg_width`. A mismatch raises error 1. `pix_cnt` is then set to 0.
  - `line_cnt` increments on each `line` edge and saturates.
  - On a `done` edge, `line_cnt` (including a same-cycle `line` edge) is compared to `cfg_height`. A mismatch raises error 2.
- Overflow: `axis_i.vld=1` while `axis_i.rdy=0` in RUN raises error 4. The deframer does not hold `vld`, so that pixel is lost.
- Skid buffer:
  - 2 entries, FIFO order.
  - `axis_i.rdy = (count<2)` in RUN.
  - Simultaneous push and pop keeps count unchanged.
- Errors:
  - The first error is latched; later errors are ignored until cleared.
  - Same-cycle priority: 4 > 1 > 2 > 3.
- `start` in RUN, DRAIN or FIN is ignored.

## Timing
- Reset values: state IDLE, `axis_i.rdy=0` during reset, `axis_o.vld=0`, `axis_o.data=0`, `busy=0`, `frame_done=0`, `err=0`, `err_code=0`, `line_cnt=0`, `pix_cnt=0`, buffer empty.
- Pass-through latency is 1 cycle: a pixel accepted at cycle N is on `axis_o` from N+1.
- Throughput is 1 pixel/cycle while `axis_o.rdy=1`.
- `axis_o.vld`/`data` are held stable until `axis_o.rdy`; `vld` never drops without a handshake, except on abort/ERR/reset.
- An error detected at cycle N gives `err=1` and state ERR at N+1. `axis_o.vld=0` from N+1.
- `frame_done` pulses exactly one cycle after the cycle in which the last buffered pixel handshakes. If the buffer is already empty at the `done` edge, it pulses 2 cycles after that edge.
- `line_cnt`/`pix_cnt` hold their final values through IDLE. They clear on `start`.

## Configuration
- `FRAME_TIMEOUT_EN`: when defined, a watchdog counts consecutive RUN cycles with no acceptance. The counter is cleared on acceptance and on entry to RUN. Reaching `TIMEOUT_CYC` raises error 3.
- When undefined, there is no watchdog counter, error 3 is never produced, and `TIMEOUT_CYC` is ignored.

## Test plan
- Clean frame: `cfg_width=4`, `cfg_height=2`, `start`, 8 pixels 0x010101..0x080808, `line` with pixels 4 and 8, `done` -> 8 pixels out in order at 1-cycle latency; `line_cnt=2`; single `frame_done`; `err=0`.
- Width error: `cfg_width=4`, `line` after 3 pixels -> `err=1`, `err_code=1` next cycle; `axis_o.vld=0`; `axis_i.rdy=1`; a following `start` clears `err` and re-enters RUN.
- Backpressure: `axis_o.rdy=0` for 5 cycles mid-line -> `axis_i.rdy` drops after 2 buffered; no loss or reorder. A deframer `vld` pulse during `rdy=0` -> `err_code=4`.
- Abort: `abort` in RUN with 2 pixels buffered -> next cycle IDLE, `axis_o.vld=0`, `busy=0`, no `frame_done`, `err=0`.
- Coincident edges: last `line` and `done` edges in the same cycle with `cfg_height=3` after 3 lines -> no error; `frame_done` pulses. Repeat with `cfg_height=4` -> `err_code=2`.
- Timeout and reset:
  - With `FRAME_TIMEOUT_EN`, `TIMEOUT_CYC=16`: `start`, then no pixels -> `err_code=3` on the 16th idle cycle's following edge.
  - Without the macro: no error after 100 idle cycles.
  - `rst=0` mid-frame -> all outputs at reset values after the next edge.
